serializer_nto1: RTL and testbench

SERIALIZER_NTO1 -- requirements
Module: serializer_nto1

---
 rtl/serializer_nto1.sv | 100 ++++++++++
 tb/tb_serializer_nto1.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serializer_nto1.sv
// serializer_nto1: DATA_WIDTH-to-OUT_WIDTH serializer, LSB first, with continuous BEATS-cycle framing.
// Define SERIALIZER_UNDERFLOW_EN to build the sticky underflow flag; otherwise o_underflow is tied low.
module serializer_nto1 #(
    parameter int                    DATA_WIDTH = 10,
    parameter int                    OUT_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 10'h354
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_word_start,
    output logic                  o_underflow
);

    localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if ((DATA_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
            $error("serializer_nto1: DATA_WIDTH must be a multiple of OUT_WIDTH");
        end
        if (BEATS < 2) begin : g_bad_beats
            $error("serializer_nto1: DATA_WIDTH/OUT_WIDTH must be at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] sr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] hb;
    logic                  hb_v;
    logic                  boundary;
    logic                  accept;

    // Handshake: a word transfers on a rising edge where i_valid && o_ready; the source may hold
    // i_valid/i_data across cycles, and both are ignored while o_ready is low.
    assign o_ready  = !hb_v && !i_rst;
    assign accept   = i_valid && o_ready;
    assign boundary = (cnt == LAST_BEAT);

    assign o_data       = sr[OUT_WIDTH-1:0];
    assign o_word_start = (cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr  <= '0;
            cnt <= LAST_BEAT;
        end else if (boundary) begin
            sr  <= hb_v ? hb : IDLE_WORD;
            cnt <= '0;
        end else begin
            sr  <= sr >> OUT_WIDTH;
            cnt <= cnt + 1'b1;
        end
    end

    // accept needs hb_v=0 and the boundary only clears hb_v when it was 1, so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hb_v <= 1'b0;
        end else if (accept) begin
            hb_v <= 1'b1;
        end else if (boundary) begin
            hb_v <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            hb <= i_data;
        end
    end

`ifdef SERIALIZER_UNDERFLOW_EN
    logic started;
    logic underflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            started   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (accept) begin
                started <= 1'b1;
            end
            if (boundary && !hb_v && started) begin
                underflow <= 1'b1;
            end
        end
    end

    assign o_underflow = underflow;
`else
    assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_nto1.sv
// Bench for serializer_nto1: directed scenarios plus random traffic, checked beat by beat
// against a frame-level model of the emitted words.
module tb_serializer_nto1;

    localparam int DW    = 10;
    localparam int OW    = 2;
    localparam int BEATS = DW / OW;
    localparam logic [DW-1:0] IDLE = 10'h354;
`ifdef SERIALIZER_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    // clock / reset
    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          ready;
    logic [OW-1:0] sdata;
    logic          wstart;
    logic          uflow;

    always #5 clk = ~clk;

    serializer_nto1 #(
        .DATA_WIDTH(DW),
        .OUT_WIDTH (OW),
        .IDLE_WORD (IDLE)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_valid     (valid),
        .o_ready     (ready),
        .o_data      (sdata),
        .o_word_start(wstart),
        .o_underflow (uflow)
    );

    // scoreboard: exp_q holds accepted words not yet framed; m_word is the word on the line,
    // m_k the beat index within its frame.
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_word;
    int            m_k;
    bit            m_started;
    bit            m_uf;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one clock cycle with the given inputs; outputs sampled at the falling edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        output logic acc, output logic [OW-1:0] od, output logic ows);
        logic [DW-1:0] sh;
        logic          exp_ready;
        valid = v;
        data  = d;
        rst   = r;
        @(negedge clk);
        sh        = m_word >> (m_k * OW);
        exp_ready = (exp_q.size() == 0) && !r;
        od        = sdata;
        ows       = wstart;
        check("o_data", DW'(sdata), DW'(sh[OW-1:0]));
        check("o_word_start", DW'(wstart), DW'(m_k == 0));
        check("o_ready", DW'(ready), DW'(exp_ready));
        check("o_underflow", DW'(uflow), DW'(m_uf));
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            m_word    = '0;
            m_k       = BEATS - 1;
            exp_q.delete();
            m_started = 1'b0;
            m_uf      = 1'b0;
        end else begin
            if (m_k == BEATS - 1) begin
                if (exp_q.size() > 0) begin
                    m_word = exp_q.pop_front();
                end else begin
                    m_word = IDLE;
                    if (UF_EN && m_started) m_uf = 1'b1;
                end
                m_k = 0;
            end else begin
                m_k++;
            end
            if (acc) begin
                exp_q.push_back(d);
                m_started = 1'b1;
            end
        end
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        logic          acc;
        logic [OW-1:0] od;
        logic          ows;
        int            tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 4 * BEATS) begin
            step(1'b1, w, 1'b0, acc, od, ows);
            tries++;
        end
    endtask

    task automatic idle(input int n);
        logic          acc;
        logic [OW-1:0] od;
        logic          ows;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc, od, ows);
    endtask

    // release from reset and confirm the next frame is the idle word, beat by beat
    task automatic release_and_check_idle(input string tag);
        logic          acc;
        logic [OW-1:0] od;
        logic          ows;
        logic [OW-1:0] idle_beats [BEATS];
        idle_beats = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        step(1'b0, '0, 1'b0, acc, od, ows);
        for (int i = 0; i < BEATS; i++) begin
            step(1'b0, '0, 1'b0, acc, od, ows);
            check(tag, DW'(od), DW'(idle_beats[i]));
            check({tag, "_start"}, DW'(ows), DW'(i == 0));
        end
    endtask

    initial begin
        logic          acc;
        logic [OW-1:0] od;
        logic          ows;
        logic          v;
        logic          r;
        m_word    = '0;
        m_k       = BEATS - 1;
        m_started = 1'b0;
        m_uf      = 1'b0;

        // three reset cycles; the first edge puts the DUT into its reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step(1'b0, '0, 1'b1, acc, od, ows);
        release_and_check_idle("idle_after_reset");
        idle(10);

        // single all-ones word
        send(10'h3FF);
        idle(2 * BEATS);

        // back-to-back words with valid held high, then starve the line
        send(10'h001);
        send(10'h3FE);
        send(10'h2AA);
        idle(3 * BEATS);

        // reset at beat 2 of a 3FF frame while another word sits in the buffer
        send(10'h3FF);
        send(10'h155);
        for (int i = 0; i < 2 * BEATS && !(m_word == 10'h3FF && m_k == 2); i++) begin
            step(1'b0, '0, 1'b0, acc, od, ows);
        end
        check("mid_frame_beat2", DW'(m_k), DW'(2));
        step(1'b0, '0, 1'b1, acc, od, ows);
        step(1'b1, 10'h0F0, 1'b1, acc, od, ows);
        check("reset_o_data", DW'(od), DW'(0));
        check("reset_o_ready", DW'(ready), DW'(0));
        release_and_check_idle("idle_after_mid_reset");

        // random traffic with occasional resets
        for (int n = 0; n < 250; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 79) == 0);
            step(v, DW'($urandom), r, acc, od, ows);
        end
        idle(2 * BEATS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
